aes_decrypt_192: RTL and testbench

AES_DECRYPT_192 -- requirements
Module: aes_decrypt_192

---
 rtl/aes_pkg.sv | 90 +++++++++
 rtl/aes192_key_expand.sv | 28 ++
 rtl/aes_decrypt_192.sv | 163 ++++++++++++++++
 tb/tb_aes_decrypt_192.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the AES-192 decryptor.
// The S-boxes use a GF inverse followed by the affine map instead of 256-entry tables.
package aes_pkg;

  typedef logic [127:0] state_t;

  localparam logic [7:0] RCON [0:7] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                        8'h10, 8'h20, 8'h40, 8'h80};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 for nonzero a, and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic state_t inv_sub_bytes(input state_t s);
    state_t o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte 4c+r sits at row r, column c; row r rotates right by r columns.
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes192_key_expand.sv
// Combinational AES-192 key schedule (Nk=6, Nr=12): 52 words packed into 13 round keys.
module aes192_key_expand
  import aes_pkg::*;
(
  input  logic [191:0]        key,
  output logic [0:12][127:0]  rk
);

  logic [31:0] w [0:51];

  always_comb begin
    logic [31:0] t;
    t = '0;
    for (int unsigned i = 0; i < 6; i++)
      w[i] = key[191-32*i -: 32];
    for (int unsigned i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {RCON[i/6-1], 24'h000000};
      w[i] = w[i-6] ^ t;
    end
  end

  for (genvar n = 0; n < 13; n++) begin : g_rk
    assign rk[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  end

endmodule

// File: rtl/aes_decrypt_192.sv
// Iterative AES-192 decryptor: one inverse round per clock, done 13 edges after start.
// Define AES_DEC_DEBUG_EN to expose registered round states and the expanded round keys.
module aes_decrypt_192
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipher,
  input  logic [191:0] key,
  output logic [127:0] plain,
  output logic         busy,
  output logic         done,
  output logic [127:0] key0,
  output logic [127:0] key1,
  output logic [127:0] key2,
  output logic [127:0] key3,
  output logic [127:0] key4,
  output logic [127:0] key5,
  output logic [127:0] key6,
  output logic [127:0] key7,
  output logic [127:0] key8,
  output logic [127:0] key9,
  output logic [127:0] key10,
  output logic [127:0] key11,
  output logic [127:0] key12,
  output logic [127:0] round0,
  output logic [127:0] round1,
  output logic [127:0] round2,
  output logic [127:0] round3,
  output logic [127:0] round4,
  output logic [127:0] round5,
  output logic [127:0] round6,
  output logic [127:0] round7,
  output logic [127:0] round8,
  output logic [127:0] round9,
  output logic [127:0] round10,
  output logic [127:0] round11
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROUND, S_FINAL} fsm_e;

  fsm_e              fsm_q;
  state_t            st_q, st_d, plain_q;
  state_t            rk_sel, inv_core;
  logic [191:0]      key_q;
  logic [3:0]        rnd_q;
  logic              busy_q, done_q;
  logic [0:12][127:0] rk;
  logic [0:12][127:0] dbg_key;
  logic [0:11][127:0] dbg_round;

  aes192_key_expand u_key_expand (
    .key (key_q),
    .rk  (rk)
  );

  // rnd_q is 0 in S_INIT and reaches 12 in S_FINAL, so one mux picks key(12-N) for every step.
  always_comb begin
    rk_sel   = rk[4'd12 - rnd_q];
    inv_core = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_sel;
    case (fsm_q)
      S_INIT:  st_d = st_q ^ rk_sel;
      S_ROUND: st_d = inv_mix_columns(inv_core);
      default: st_d = inv_core;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      st_q    <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
      plain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        S_IDLE: begin
          if (start) begin
            st_q   <= cipher;
            key_q  <= key;
            rnd_q  <= '0;
            busy_q <= 1'b1;
            fsm_q  <= S_INIT;
          end
        end
        S_INIT: begin
          st_q  <= st_d;
          rnd_q <= rnd_q + 4'd1;
          fsm_q <= S_ROUND;
        end
        S_ROUND: begin
          st_q  <= st_d;
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == 4'd11) fsm_q <= S_FINAL;
        end
        S_FINAL: begin
          plain_q <= st_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          fsm_q   <= S_IDLE;
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

`ifdef AES_DEC_DEBUG_EN
  logic               key_valid_q;
  logic [0:11][127:0] round_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_q <= 1'b0;
      round_q     <= '0;
    end else begin
      if (fsm_q == S_IDLE && start) key_valid_q <= 1'b1;
      if (fsm_q == S_INIT || fsm_q == S_ROUND) round_q[rnd_q] <= st_d;
    end
  end

  assign dbg_key   = key_valid_q ? rk : '0;
  assign dbg_round = round_q;
`else
  assign dbg_key   = '0;
  assign dbg_round = '0;
`endif

  assign plain = plain_q;
  assign busy  = busy_q;
  assign done  = done_q;

  assign key0  = dbg_key[0];
  assign key1  = dbg_key[1];
  assign key2  = dbg_key[2];
  assign key3  = dbg_key[3];
  assign key4  = dbg_key[4];
  assign key5  = dbg_key[5];
  assign key6  = dbg_key[6];
  assign key7  = dbg_key[7];
  assign key8  = dbg_key[8];
  assign key9  = dbg_key[9];
  assign key10 = dbg_key[10];
  assign key11 = dbg_key[11];
  assign key12 = dbg_key[12];

  assign round0  = dbg_round[0];
  assign round1  = dbg_round[1];
  assign round2  = dbg_round[2];
  assign round3  = dbg_round[3];
  assign round4  = dbg_round[4];
  assign round5  = dbg_round[5];
  assign round6  = dbg_round[6];
  assign round7  = dbg_round[7];
  assign round8  = dbg_round[8];
  assign round9  = dbg_round[9];
  assign round10 = dbg_round[10];
  assign round11 = dbg_round[11];

endmodule

// File: tb/tb_aes_decrypt_192.sv
// Self-checking bench for aes_decrypt_192: plaintexts are encrypted by a forward AES-192
// model here, and the DUT must recover them; debug ports are checked when AES_DEC_DEBUG_EN is set.
module tb_aes_decrypt_192;

`ifdef AES_DEC_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  localparam logic [191:0] V1K = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] V1C = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] V1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1K12 = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [127:0] V1R0  = 128'h793e76979c3403e9aab7b2d10fa96ccc;
  localparam logic [127:0] V2C = 128'haae06992acbf52a3e8f4a96ec9300bd7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] cipher = '0;
  logic [191:0] key = '0;
  logic [127:0] plain;
  logic         busy, done;
  logic [127:0] k_o [0:12];
  logic [127:0] r_o [0:11];

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]   sb [256];
  logic [31:0]  m_w [52];
  logic [127:0] m_rk [13];
  logic [127:0] m_t [12];

  always #5 clk = ~clk;

  aes_decrypt_192 dut (
    .clk(clk), .rst(rst), .start(start), .cipher(cipher), .key(key),
    .plain(plain), .busy(busy), .done(done),
    .key0(k_o[0]), .key1(k_o[1]), .key2(k_o[2]), .key3(k_o[3]), .key4(k_o[4]),
    .key5(k_o[5]), .key6(k_o[6]), .key7(k_o[7]), .key8(k_o[8]), .key9(k_o[9]),
    .key10(k_o[10]), .key11(k_o[11]), .key12(k_o[12]),
    .round0(r_o[0]), .round1(r_o[1]), .round2(r_o[2]), .round3(r_o[3]),
    .round4(r_o[4]), .round5(r_o[5]), .round6(r_o[6]), .round7(r_o[7]),
    .round8(r_o[8]), .round9(r_o[9]), .round10(r_o[10]), .round11(r_o[11])
  );

  // ---------------- reference model (forward cipher) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    logic [8:0] t;
    t = {a, 1'b0};
    if (t[8]) t = t ^ 9'h11b;
    return t[7:0];
  endfunction

  // S-box from walking the multiplicative group with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sb[s[127-8*(4*((c+r)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  task automatic model_keys(input logic [191:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) m_w[i] = k[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = m_w[i-1];
      if (i % 6 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      m_w[i] = m_w[i-6] ^ t;
    end
    for (int n = 0; n < 13; n++) m_rk[n] = {m_w[4*n], m_w[4*n+1], m_w[4*n+2], m_w[4*n+3]};
  endtask

  // m_t[j] = ShiftRows(SubBytes(s_j)); the decryptor's roundN equals m_t[11-N].
  task automatic model_encrypt(input logic [127:0] p, input logic [191:0] k, output logic [127:0] ct);
    logic [127:0] s, u;
    model_keys(k);
    s = p ^ m_rk[0];
    for (int r = 1; r < 12; r++) begin
      u = sub_shift(s);
      m_t[r-1] = u;
      s = mix(u) ^ m_rk[r];
    end
    u = sub_shift(s);
    m_t[11] = u;
    ct = u ^ m_rk[12];
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [127:0] c, input logic [191:0] k);
    @(negedge clk);
    cipher = c;
    key    = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    cipher = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (plain !== '0) begin n_fail++; $display("FAIL reset_plain: got %h expected 0", plain); end
    for (int n = 0; n < 13; n++) begin
      n_checks++; if (k_o[n] !== '0) begin n_fail++; $display("FAIL reset_key%0d: got %h expected 0", n, k_o[n]); end
    end
    for (int n = 0; n < 12; n++) begin
      n_checks++; if (r_o[n] !== '0) begin n_fail++; $display("FAIL reset_round%0d: got %h expected 0", n, r_o[n]); end
    end
    rst = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_vector1();
    int lat;
    do_start(V1C, V1K);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL v1_busy: got %b expected 1", busy); end
    n_checks++; if (k_o[0] !== (DBG ? V1K0 : 128'h0)) begin n_fail++; $display("FAIL v1_key0_early: got %h expected %h", k_o[0], DBG ? V1K0 : 128'h0); end
    wait_done(lat);
    n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL v1_latency: got %0d expected 13", lat); end
    n_checks++; if (plain !== V1P) begin n_fail++; $display("FAIL v1_plain: got %h expected %h", plain, V1P); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL v1_busy_done: got %b expected 0", busy); end
    n_checks++; if (k_o[12] !== (DBG ? V1K12 : 128'h0)) begin n_fail++; $display("FAIL v1_key12: got %h expected %h", k_o[12], DBG ? V1K12 : 128'h0); end
    n_checks++; if (r_o[0] !== (DBG ? V1R0 : 128'h0)) begin n_fail++; $display("FAIL v1_round0: got %h expected %h", r_o[0], DBG ? V1R0 : 128'h0); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL v1_done_pulse: got %b expected 0", done); end
    n_checks++; if (plain !== V1P) begin n_fail++; $display("FAIL v1_plain_hold: got %h expected %h", plain, V1P); end
  endtask

  task automatic test_vector2();
    int lat;
    do_start(V2C, 192'h0);
    wait_done(lat);
    n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL v2_latency: got %0d expected 13", lat); end
    n_checks++; if (plain !== 128'h0) begin n_fail++; $display("FAIL v2_plain: got %h expected 0", plain); end
  endtask

  task automatic test_random();
    logic [127:0] p, ct;
    logic [191:0] k;
    int lat;
    for (int it = 0; it < 6; it++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      model_encrypt(p, k, ct);
      do_start(ct, k);
      wait_done(lat);
      n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d expected 13", it, lat); end
      n_checks++; if (plain !== p) begin n_fail++; $display("FAIL rnd%0d_plain: got %h expected %h", it, plain, p); end
      for (int n = 0; n < 13; n++) begin
        n_checks++;
        if (k_o[n] !== (DBG ? m_rk[n] : 128'h0)) begin
          n_fail++; $display("FAIL rnd%0d_key%0d: got %h expected %h", it, n, k_o[n], DBG ? m_rk[n] : 128'h0);
        end
      end
      for (int n = 0; n < 12; n++) begin
        n_checks++;
        if (r_o[n] !== (DBG ? m_t[11-n] : 128'h0)) begin
          n_fail++; $display("FAIL rnd%0d_round%0d: got %h expected %h", it, n, r_o[n], DBG ? m_t[11-n] : 128'h0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] p1, p2, c1, c2;
    logic [191:0] k1, k2;
    int lat;
    bit held;
    p1 = {$urandom, $urandom, $urandom, $urandom};
    p2 = {$urandom, $urandom, $urandom, $urandom};
    k1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    model_encrypt(p2, k2, c2);
    model_encrypt(p1, k1, c1);
    do_start(c1, k1);
    wait_done(lat);
    n_checks++; if (plain !== p1) begin n_fail++; $display("FAIL b2b_first_plain: got %h expected %h", plain, p1); end
    cipher = c2;
    key    = k2;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    held = 1'b1;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (plain !== p1) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL b2b_hold: got %b expected 1", held); end
    n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 13", lat); end
    n_checks++; if (plain !== p2) begin n_fail++; $display("FAIL b2b_second_plain: got %h expected %h", plain, p2); end
  endtask

  task automatic test_busy_start();
    int lat;
    do_start(V1C, V1K);
    repeat (4) @(negedge clk);
    cipher = {$urandom, $urandom, $urandom, $urandom};
    key    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(lat);
    n_checks++; if (lat + 5 !== 13) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 13", lat + 5); end
    n_checks++; if (plain !== V1P) begin n_fail++; $display("FAIL busy_start_plain: got %h expected %h", plain, V1P); end
    n_checks++; if (k_o[0] !== (DBG ? V1K0 : 128'h0)) begin n_fail++; $display("FAIL busy_start_key0: got %h expected %h", k_o[0], DBG ? V1K0 : 128'h0); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] p, ct;
    logic [191:0] k;
    int lat;
    bit saw;
    do_start(V1C, V1K);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (plain !== '0) begin n_fail++; $display("FAIL mid_reset_plain: got %h expected 0", plain); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_done: got %b expected 0", done); end
    for (int n = 0; n < 13; n++) begin
      n_checks++; if (k_o[n] !== '0) begin n_fail++; $display("FAIL mid_reset_key%0d: got %h expected 0", n, k_o[n]); end
    end
    for (int n = 0; n < 12; n++) begin
      n_checks++; if (r_o[n] !== '0) begin n_fail++; $display("FAIL mid_reset_round%0d: got %h expected 0", n, r_o[n]); end
    end
    rst = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_done: got %b expected 0", saw); end
    p = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    model_encrypt(p, k, ct);
    do_start(ct, k);
    wait_done(lat);
    n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 13", lat); end
    n_checks++; if (plain !== p) begin n_fail++; $display("FAIL post_reset_plain: got %h expected %h", plain, p); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    test_reset();
    test_vector1();
    test_vector2();
    test_random();
    test_back_to_back();
    test_busy_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
